// File: rtl/cha_bus_sched_pkg.sv
// cha_bus_sched_pkg: shared state encodings, owner codes and default timing for the CHA bus scheduler
package cha_bus_sched_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LATCH, S_WAIT, S_CAPTURE} state_t;
    typedef enum logic {OWN_SPR, OWN_FIX} owner_t;
    localparam int PCK_CYC_DEF    = 2;
    localparam int DATA_WAIT_DEF  = 3;
    localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/cha_bus_sched_arb.sv
// cha_bus_sched_arb: sprite-priority winner select with a saturating fix starvation guard
module cha_bus_sched_arb
    import cha_bus_sched_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk_24m,
    input  logic reset,
    input  logic idle,
    input  logic spr_req,
    input  logic fix_req,
    output logic win_spr,
    output logic win_fix
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] cnt;
    assign win_fix = fix_req && (!spr_req || cnt == SW'(STARVE_MAX));
    assign win_spr = spr_req && !win_fix;
    // counts sprite grants that left a pending fix request waiting
    always_ff @(posedge clk_24m) begin
        if (reset)
            cnt <= '0;
        else if (idle && win_fix)
            cnt <= '0;
        else if (idle && win_spr)
            cnt <= fix_req ? (cnt == SW'(STARVE_MAX) ? cnt : cnt + 1'b1) : '0;
    end
endmodule

// File: rtl/cha_bus_sched.sv
// cha_bus_sched: shares the cartridge CHA bus between sprite and fix fetchers with latch/wait/capture timing
module cha_bus_sched
    import cha_bus_sched_pkg::*;
#(
    parameter int PCK_CYC    = PCK_CYC_DEF,
    parameter int DATA_WAIT  = DATA_WAIT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk_24m,
    input  logic        reset,
    input  logic        spr_req,
    input  logic [19:0] spr_addr,
    input  logic        spr_ca4,
    output logic        spr_ack,
    output logic        spr_valid,
    output logic [31:0] spr_data,
    input  logic        fix_req,
    input  logic [15:0] fix_addr,
    input  logic        fix_s2h1,
    output logic        fix_ack,
    output logic        fix_valid,
    output logic [7:0]  fix_data,
    output logic [19:0] pbus_out,
    output logic        pbus_oe,
    output logic        pck1b,
    output logic        pck2b,
    output logic        ca4,
    output logic        s2h1,
    input  logic [31:0] cr,
    input  logic [7:0]  fixd,
    output logic        busy
);
    localparam int CW = $clog2((PCK_CYC > DATA_WAIT ? PCK_CYC : DATA_WAIT) + 1);
    state_t        state, state_n;
    owner_t        owner;
    logic [CW-1:0] cnt, cnt_n;
    logic          sel, win_spr, win_fix;
    cha_bus_sched_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
        .clk_24m (clk_24m),
        .reset   (reset),
        .idle    (state == S_IDLE),
        .spr_req (spr_req),
        .fix_req (fix_req),
        .win_spr (win_spr),
        .win_fix (win_fix)
    );
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (win_spr || win_fix) state_n = S_ADDR;
            end
            S_ADDR: begin
                cnt_n   = '0;
                state_n = S_LATCH;
            end
            S_LATCH: if (cnt == CW'(PCK_CYC - 1)) begin
                cnt_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: if (cnt == CW'(DATA_WAIT - 1)) begin
                cnt_n   = '0;
                state_n = S_CAPTURE;
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_24m) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            owner     <= OWN_SPR;
            sel       <= 1'b0;
            pbus_out  <= '0;
            spr_valid <= 1'b0;
            fix_valid <= 1'b0;
            spr_data  <= '0;
            fix_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            spr_valid <= state == S_CAPTURE && owner == OWN_SPR;
            fix_valid <= state == S_CAPTURE && owner == OWN_FIX;
            if (state == S_IDLE && win_spr) begin
                owner    <= OWN_SPR;
                sel      <= spr_ca4;
                pbus_out <= spr_addr;
            end else if (state == S_IDLE && win_fix) begin
                owner    <= OWN_FIX;
                sel      <= fix_s2h1;
                pbus_out <= {4'b0, fix_addr};
            end
            if (state == S_CAPTURE && owner == OWN_SPR) spr_data <= cr;
            if (state == S_CAPTURE && owner == OWN_FIX) fix_data <= fixd;
        end
    end
    assign busy    = state != S_IDLE;
    assign spr_ack = state == S_ADDR && owner == OWN_SPR;
    assign fix_ack = state == S_ADDR && owner == OWN_FIX;
    assign pbus_oe = state == S_ADDR || state == S_LATCH;
    assign pck1b   = !(state == S_LATCH && owner == OWN_SPR);
    assign pck2b   = !(state == S_LATCH && owner == OWN_FIX);
    assign ca4     = busy && owner == OWN_SPR && sel;
    assign s2h1    = busy && owner == OWN_FIX && sel;
endmodule

// File: tb/tb_cha_bus_sched.sv
// tb_cha_bus_sched: scoreboard bench for the CHA bus scheduler with a simple latching cart model
module tb_cha_bus_sched;
    logic        clk = 1'b0, rst1, rst2, cart_mode;
    logic        spr_req, spr_ca4, fix_req, fix_s2h1;
    logic [19:0] spr_addr;
    logic [15:0] fix_addr;
    logic [31:0] cr, cr_drv;
    logic [7:0]  fixd, fixd_drv;
    logic        spr_ack, spr_valid, fix_ack, fix_valid, pbus_oe, pck1b, pck2b, ca4, s2h1, busy;
    logic [31:0] spr_data;
    logic [7:0]  fix_data;
    logic [19:0] pbus_out;
    logic        d2_spr_ack, d2_spr_valid, d2_fix_ack, d2_fix_valid, d2_pbus_oe;
    logic        d2_pck1b, d2_pck2b, d2_ca4, d2_s2h1, d2_busy;
    logic [31:0] d2_spr_data;
    logic [7:0]  d2_fix_data;
    logic [19:0] d2_pbus_out;
    logic [20:0] lat_s;
    logic [16:0] lat_f;
    logic [31:0] spr_q[$];
    logic [7:0]  fix_q[$];
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    cha_bus_sched dut (
        .clk_24m(clk), .reset(rst1),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_ca4(spr_ca4),
        .spr_ack(spr_ack), .spr_valid(spr_valid), .spr_data(spr_data),
        .fix_req(fix_req), .fix_addr(fix_addr), .fix_s2h1(fix_s2h1),
        .fix_ack(fix_ack), .fix_valid(fix_valid), .fix_data(fix_data),
        .pbus_out(pbus_out), .pbus_oe(pbus_oe), .pck1b(pck1b), .pck2b(pck2b),
        .ca4(ca4), .s2h1(s2h1), .cr(cr), .fixd(fixd), .busy(busy)
    );

    cha_bus_sched #(.PCK_CYC(1), .DATA_WAIT(1)) dut2 (
        .clk_24m(clk), .reset(rst2),
        .spr_req(spr_req), .spr_addr(spr_addr), .spr_ca4(spr_ca4),
        .spr_ack(d2_spr_ack), .spr_valid(d2_spr_valid), .spr_data(d2_spr_data),
        .fix_req(fix_req), .fix_addr(fix_addr), .fix_s2h1(fix_s2h1),
        .fix_ack(d2_fix_ack), .fix_valid(d2_fix_valid), .fix_data(d2_fix_data),
        .pbus_out(d2_pbus_out), .pbus_oe(d2_pbus_oe), .pck1b(d2_pck1b), .pck2b(d2_pck2b),
        .ca4(d2_ca4), .s2h1(d2_s2h1), .cr(cr), .fixd(fixd), .busy(d2_busy)
    );

    function automatic logic [31:0] cr_of(input logic [19:0] a, input logic c);
        return {c, a[10:0], a};
    endfunction

    function automatic logic [7:0] fix_of(input logic [15:0] a, input logic s);
        return a[7:0] ^ a[15:8] ^ {7'b0, s};
    endfunction

    // cart latches the address on the low strobe and answers from it
    always @(posedge clk) begin
        if (!pck1b) lat_s <= {pbus_out, ca4};
        if (!pck2b) lat_f <= {pbus_out[15:0], s2h1};
    end
    assign cr   = cart_mode ? cr_of(lat_s[20:1], lat_s[0]) : cr_drv;
    assign fixd = cart_mode ? fix_of(lat_f[16:1], lat_f[0]) : fixd_drv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (spr_valid) begin
            chk("spr_sb_pending", spr_q.size() > 0, 1);
            if (spr_q.size() > 0) chk("spr_data", spr_data, spr_q.pop_front());
        end
        if (fix_valid) begin
            chk("fix_sb_pending", fix_q.size() > 0, 1);
            if (fix_q.size() > 0) chk("fix_data", {24'b0, fix_data}, {24'b0, fix_q.pop_front()});
        end
    end

    task automatic new_addrs();
        spr_addr = 20'($urandom);
        fix_addr = 16'($urandom);
        spr_ca4  = 1'($urandom);
        fix_s2h1 = 1'($urandom);
    endtask

    task automatic check_txn(input bit is_fix, input logic [19:0] pb, input logic sel);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("ack_c%0d", c), is_fix ? fix_ack : spr_ack, c == 1);
            chk($sformatf("other_ack_c%0d", c), is_fix ? spr_ack : fix_ack, 0);
            chk($sformatf("own_pck_c%0d", c), is_fix ? pck2b : pck1b, !(c == 2 || c == 3));
            chk($sformatf("other_pck_c%0d", c), is_fix ? pck1b : pck2b, 1);
            chk($sformatf("oe_c%0d", c), pbus_oe, c <= 3);
            chk($sformatf("busy_c%0d", c), busy, c <= 7);
            chk($sformatf("pbus_c%0d", c), pbus_out, pb);
            chk($sformatf("sel_c%0d", c), is_fix ? s2h1 : ca4, c <= 7 && sel);
            chk($sformatf("valid_c%0d", c), is_fix ? fix_valid : spr_valid, c == 8);
            if (c == 1) begin
                spr_req = 1'b0;
                fix_req = 1'b0;
                new_addrs();
            end
        end
    endtask

    task automatic wait_ack(output bit f, output int dt);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!spr_ack && !fix_ack && t < 40);
        chk("ack_seen", spr_ack || fix_ack, 1);
        if (spr_ack) spr_q.push_back(cr_of(spr_addr, spr_ca4));
        else if (fix_ack) fix_q.push_back(fix_of(fix_addr, fix_s2h1));
        f  = fix_ack;
        dt = t;
        new_addrs();
    endtask

    initial begin
        bit f;
        int dt, nv;
        bit exp_fix[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        rst1 = 1; rst2 = 1; cart_mode = 0; spr_req = 0; fix_req = 0;
        spr_addr = '0; fix_addr = '0; spr_ca4 = 0; fix_s2h1 = 0; cr_drv = '0; fixd_drv = '0;
        repeat (2) @(negedge clk);
        rst1 = 0;
        chk("rst_pck1b", pck1b, 1);
        chk("rst_pck2b", pck2b, 1);
        chk("rst_oe", pbus_oe, 0);
        chk("rst_pbus", pbus_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", {ca4, s2h1}, 0);
        chk("rst_ack", {spr_ack, fix_ack}, 0);
        chk("rst_valid", {spr_valid, fix_valid}, 0);
        chk("rst_spr_data", spr_data, 0);
        chk("rst_fix_data", {24'b0, fix_data}, 0);
        @(negedge clk);
        spr_addr = 20'hABCDE; spr_ca4 = 1; cr_drv = 32'h12345678; spr_req = 1;
        spr_q.push_back(32'h12345678);
        check_txn(0, 20'hABCDE, 1);
        fix_addr = 16'h1234; fix_s2h1 = 1; fixd_drv = 8'h5A; fix_req = 1;
        fix_q.push_back(8'h5A);
        check_txn(1, 20'h01234, 1);
        chk("spr_data_hold", spr_data, 32'h12345678);
        // reset while the strobe is low drops the fetch
        @(negedge clk);
        spr_addr = 20'h13579; spr_req = 1;
        @(negedge clk);
        spr_req = 0;
        @(negedge clk);
        chk("pre_rst_pck1b", pck1b, 0);
        rst1 = 1;
        @(negedge clk);
        chk("mid_rst_pck1b", pck1b, 1);
        chk("mid_rst_oe", pbus_oe, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst1 = 0;
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            nv += int'(spr_valid);
        end
        chk("rst_dropped_valid", nv, 0);
        // both held: fix wins after STARVE_MAX sprite grants
        cart_mode = 1;
        new_addrs();
        spr_req = 1; fix_req = 1;
        for (int i = 0; i < 10; i++) begin
            wait_ack(f, dt);
            chk($sformatf("starve_order_%0d", i), f, exp_fix[i]);
            if (i > 0) chk($sformatf("starve_gap_%0d", i), dt, 8);
        end
        spr_req = 0; fix_req = 0;
        repeat (10) @(negedge clk);
        // a fix pulse while busy must not be granted nor disturb the counter
        rst1 = 1;
        @(negedge clk);
        rst1 = 0;
        spr_req = 1; fix_req = 1;
        for (int i = 0; i < 3; i++) begin
            wait_ack(f, dt);
            chk($sformatf("wd_pre_%0d", i), f, 0);
        end
        spr_req = 0; fix_req = 0;
        repeat (4) @(negedge clk);
        fix_req = 1;
        @(negedge clk);
        fix_req = 0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("wd_no_ack_%0d", i), fix_ack, 0);
            @(negedge clk);
        end
        chk("wd_no_ack_2", fix_ack, 0);
        spr_req = 1; fix_req = 1;
        wait_ack(f, dt);
        chk("wd_post_0", f, 0);
        wait_ack(f, dt);
        chk("wd_post_1", f, 1);
        spr_req = 0; fix_req = 0;
        repeat (10) @(negedge clk);
        // short-timing variant on the second instance
        rst1 = 1; rst2 = 0; cart_mode = 0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            cr_drv = 32'hCAFEF00D; fixd_drv = 8'hC3;
            spr_addr = 20'h2468A; fix_addr = 16'hBEEF;
            spr_req = (k == 0); fix_req = (k == 1);
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    spr_req = 0;
                    fix_req = 0;
                end
                chk($sformatf("sw%0d_ack_c%0d", k, c), k ? d2_fix_ack : d2_spr_ack, c == 1);
                chk($sformatf("sw%0d_pck_c%0d", k, c), k ? d2_pck2b : d2_pck1b, c != 2);
                chk($sformatf("sw%0d_oe_c%0d", k, c), d2_pbus_oe, c <= 2);
                chk($sformatf("sw%0d_valid_c%0d", k, c), k ? d2_fix_valid : d2_spr_valid, c == 5);
            end
            chk($sformatf("sw%0d_data", k), k ? {24'b0, d2_fix_data} : d2_spr_data,
                k ? 32'h000000C3 : 32'hCAFEF00D);
            @(negedge clk);
        end
        chk("spr_q_drain", spr_q.size(), 0);
        chk("fix_q_drain", fix_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
